// File: rtl/fixed_point_rescale_arbiter.sv
// Round-robin arbiter in front of a shared two-stage fixed-point rescaler.
// Each channel has its own signed binary-point shift and saturate/wrap mode.
//
// Handshake: a sample moves on any edge where in_valid[i] && in_ready[i].
// A result leaves on any edge where out_valid && out_ready. in_ready never
// depends on in_ready itself. While out_valid && !out_ready the whole pipe
// freezes and the output fields stay stable.
module fixed_point_rescale_arbiter #(
  parameter int NUM_CH    = 4,
  parameter int IN_W      = 16,
  parameter int OUT_W     = 16,
  parameter int SHIFT_W   = 5,
  parameter int IS_SIGNED = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CH-1:0]         in_valid,
  output logic [NUM_CH-1:0]         in_ready,
  input  logic [NUM_CH*IN_W-1:0]    in_data,
  input  logic                      cfg_wr,
  input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
  input  logic [SHIFT_W-1:0]        cfg_shift,
  input  logic                      cfg_sat_en,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OUT_W-1:0]          out_data,
  output logic [$clog2(NUM_CH)-1:0] out_ch,
  output logic                      out_sat
);

  localparam int CH_W  = $clog2(NUM_CH);
  // Wide enough to hold the largest left shift of any input exactly.
  localparam int INT_W = IN_W + (1 << (SHIFT_W - 1)) + 1;

  localparam logic signed [INT_W-1:0] MAX_S = {{(INT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [INT_W-1:0] MIN_S = {{(INT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic signed [INT_W-1:0] MAX_U = {{(INT_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};

  logic                adv;
  logic                xfer;
  logic                found;
  logic [CH_W-1:0]     cand;
  logic [CH_W-1:0]     grant_idx;
  logic [NUM_CH-1:0]   grant;
  logic [IN_W-1:0]     grant_data;
  logic [CH_W-1:0]     ptr;

  logic [SHIFT_W-1:0]  shift_tbl [NUM_CH];
  logic [NUM_CH-1:0]   sat_tbl;

  logic                s1_valid;
  logic [IN_W-1:0]     s1_data;
  logic [CH_W-1:0]     s1_ch;
  logic [SHIFT_W-1:0]  s1_shift;
  logic                s1_sat;

  logic [SHIFT_W-1:0]        mag;
  logic signed [INT_W-1:0]   ext;
  logic signed [INT_W-1:0]   scaled;
  logic [OUT_W-1:0]          res;
  logic                      res_sat;

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    adv       = !(out_valid && !out_ready);
    grant     = '0;
    grant_idx = ptr;
    found     = 1'b0;
    cand      = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      cand = CH_W'((int'(ptr) + i) % NUM_CH);
      if (!found && adv && in_valid[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
    if (found) grant[grant_idx] = 1'b1;
    xfer       = found;
    in_ready   = grant;
    grant_data = in_data[grant_idx*IN_W +: IN_W];
  end

  // Pointer follows the last accepted channel; idle cycles leave it alone.
  always_ff @(posedge clk) begin
    if (reset) ptr <= CH_W'(NUM_CH - 1);
    else if (xfer) ptr <= grant_idx;
  end

  // Per-channel config table; out-of-range channel writes are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) shift_tbl[i] <= '0;
      sat_tbl <= '1;
    end else if (cfg_wr && (int'(cfg_ch) < NUM_CH)) begin
      shift_tbl[cfg_ch] <= cfg_shift;
      sat_tbl[cfg_ch]   <= cfg_sat_en;
    end
  end

  // Stage 1 captures the sample with the config in force at transfer time.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_ch    <= '0;
      s1_shift <= '0;
      s1_sat   <= 1'b0;
    end else if (adv) begin
      s1_valid <= xfer;
      if (xfer) begin
        s1_data  <= grant_data;
        s1_ch    <= grant_idx;
        s1_shift <= shift_tbl[grant_idx];
        s1_sat   <= sat_tbl[grant_idx];
      end
    end
  end

  // Exact shift in the wide domain, then clip or wrap to the output width.
  always_comb begin
    if (IS_SIGNED != 0) ext = {{(INT_W-IN_W){s1_data[IN_W-1]}}, s1_data};
    else                ext = {{(INT_W-IN_W){1'b0}}, s1_data};
    mag = s1_shift[SHIFT_W-1] ? (~s1_shift + 1'b1) : s1_shift;
    if (s1_shift[SHIFT_W-1]) scaled = ext >>> mag;
    else                     scaled = ext << mag;
    res     = scaled[OUT_W-1:0];
    res_sat = 1'b0;
    if (s1_sat) begin
      if (IS_SIGNED != 0) begin
        if (scaled > MAX_S) begin
          res     = MAX_S[OUT_W-1:0];
          res_sat = 1'b1;
        end else if (scaled < MIN_S) begin
          res     = MIN_S[OUT_W-1:0];
          res_sat = 1'b1;
        end
      end else if (scaled > MAX_U) begin
        res     = MAX_U[OUT_W-1:0];
        res_sat = 1'b1;
      end
    end
  end

  // Output register; holds its fields whenever downstream stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      out_sat   <= 1'b0;
    end else if (adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= res;
        out_ch   <= s1_ch;
        out_sat  <= res_sat;
      end
    end
  end

endmodule

// File: tb/tb_fixed_point_rescale_arbiter.sv
// Directed bench for the rescale arbiter: a signed instance plus an unsigned
// instance sharing all inputs.
module tb_fixed_point_rescale_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  in_valid;
  logic [63:0] in_data;
  logic        cfg_wr;
  logic [1:0]  cfg_ch;
  logic [4:0]  cfg_shift;
  logic        cfg_sat_en;
  logic        out_ready;

  logic [3:0]  in_ready, u_in_ready;
  logic        out_valid, u_out_valid;
  logic [15:0] out_data, u_out_data;
  logic [1:0]  out_ch, u_out_ch;
  logic        out_sat, u_out_sat;

  int checks = 0;
  int fails  = 0;
  logic [17:0] exp_q[$];

  fixed_point_rescale_arbiter #(.NUM_CH(4), .IN_W(16), .OUT_W(16), .SHIFT_W(5), .IS_SIGNED(1)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_shift(cfg_shift), .cfg_sat_en(cfg_sat_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch), .out_sat(out_sat)
  );

  fixed_point_rescale_arbiter #(.NUM_CH(4), .IN_W(16), .OUT_W(16), .SHIFT_W(5), .IS_SIGNED(0)) u_dut_u (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(u_in_ready), .in_data(in_data),
    .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_shift(cfg_shift), .cfg_sat_en(cfg_sat_en),
    .out_valid(u_out_valid), .out_ready(out_ready), .out_data(u_out_data), .out_ch(u_out_ch), .out_sat(u_out_sat)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = '0; in_data = '0; cfg_wr = 1'b0;
    cfg_ch = '0; cfg_shift = '0; cfg_sat_en = 1'b0; out_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic cfg(input int ch, input logic [4:0] sh, input logic sat);
    cfg_wr = 1'b1; cfg_ch = 2'(ch); cfg_shift = sh; cfg_sat_en = sat;
    tick();
    cfg_wr = 1'b0;
  endtask

  task automatic send(input int ch, input logic [15:0] d);
    in_valid = '0;
    in_valid[ch] = 1'b1;
    in_data[ch*16 +: 16] = d;
    tick();
    in_valid = '0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 8) begin
      tick();
      n++;
    end
  endtask

  // Scenarios
  task automatic test_reset();
    do_reset();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'h0 || out_ch !== 2'd0 || out_sat !== 1'b0)
      begin fails++; $display("FAIL reset_outputs: got v=%0b d=%h ch=%0d sat=%0b, want 0 0000 0 0", out_valid, out_data, out_ch, out_sat); end
    #1;
    checks++;
    if (in_ready !== 4'b0000)
      begin fails++; $display("FAIL reset_idle_ready: got %b want 0000", in_ready); end
    in_valid = 4'hF;
    #1;
    checks++;
    if (in_ready !== 4'b0001 || u_in_ready !== 4'b0001)
      begin fails++; $display("FAIL reset_first_grant: got %b/%b want 0001", in_ready, u_in_ready); end
    in_valid = '0;
    do_reset();
  endtask

  task automatic test_shift_left();
    int n;
    cfg(0, 5'd4, 1'b1);
    send(0, 16'h0123);
    wait_out(n);
    checks++;
    if (n != 1 || out_valid !== 1'b1 || out_data !== 16'h1230 || out_ch !== 2'd0 || out_sat !== 1'b0)
      begin fails++; $display("FAIL shift_left: got lat=%0d v=%0b d=%h ch=%0d sat=%0b, want lat=1 v=1 d=1230 ch=0 sat=0", n, out_valid, out_data, out_ch, out_sat); end
  endtask

  task automatic test_shift_right();
    int n;
    cfg(1, 5'b11100, 1'b1);
    send(1, 16'hF800);
    wait_out(n);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'hFF80 || out_ch !== 2'd1 || out_sat !== 1'b0)
      begin fails++; $display("FAIL shift_right_neg: got v=%0b d=%h ch=%0d sat=%0b, want 1 ff80 1 0", out_valid, out_data, out_ch, out_sat); end
    send(1, 16'h0007);
    wait_out(n);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h0000 || out_ch !== 2'd1 || out_sat !== 1'b0)
      begin fails++; $display("FAIL shift_right_small: got v=%0b d=%h ch=%0d sat=%0b, want 1 0000 1 0", out_valid, out_data, out_ch, out_sat); end
  endtask

  task automatic test_saturation();
    int n;
    cfg(2, 5'd4, 1'b1);
    send(2, 16'h1000);
    wait_out(n);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h7FFF || out_ch !== 2'd2 || out_sat !== 1'b1)
      begin fails++; $display("FAIL sat_pos: got v=%0b d=%h ch=%0d sat=%0b, want 1 7fff 2 1", out_valid, out_data, out_ch, out_sat); end
    send(2, 16'hF000);
    wait_out(n);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h8000 || out_ch !== 2'd2 || out_sat !== 1'b1)
      begin fails++; $display("FAIL sat_neg: got v=%0b d=%h ch=%0d sat=%0b, want 1 8000 2 1", out_valid, out_data, out_ch, out_sat); end
    cfg(2, 5'd4, 1'b0);
    send(2, 16'h1000);
    wait_out(n);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h0000 || out_ch !== 2'd2 || out_sat !== 1'b0)
      begin fails++; $display("FAIL wrap: got v=%0b d=%h ch=%0d sat=%0b, want 1 0000 2 0", out_valid, out_data, out_ch, out_sat); end
  endtask

  task automatic test_round_robin();
    logic [17:0] e;
    int g;
    do_reset();
    exp_q.delete();
    for (int c = 0; c < 12; c++) begin
      in_valid = (c < 8) ? 4'hF : 4'h0;
      for (int i = 0; i < 4; i++) in_data[i*16 +: 16] = 16'(c*16 + i);
      #1;
      checks++;
      if (c < 8) begin
        g = c % 4;
        if (in_ready !== (4'b0001 << g))
          begin fails++; $display("FAIL rr_grant c=%0d: got %b want %b", c, in_ready, 4'b0001 << g); end
        exp_q.push_back({2'(g), 16'(c*16 + g)});
      end else if (in_ready !== 4'b0000)
        begin fails++; $display("FAIL rr_idle c=%0d: got %b want 0000", c, in_ready); end
      if (out_valid) begin
        checks++;
        if (exp_q.size() == 0)
          begin fails++; $display("FAIL rr_extra c=%0d: got ch=%0d d=%h want none", c, out_ch, out_data); end
        else begin
          e = exp_q.pop_front();
          if ({out_ch, out_data} !== e || out_sat !== 1'b0)
            begin fails++; $display("FAIL rr_out c=%0d: got ch=%0d d=%h sat=%0b want ch=%0d d=%h sat=0", c, out_ch, out_data, out_sat, e[17:16], e[15:0]); end
        end
      end
      tick();
    end
    checks++;
    if (exp_q.size() != 0)
      begin fails++; $display("FAIL rr_lost: got %0d outstanding want 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    logic [17:0] e, held;
    int mp, g;
    logic stall;
    do_reset();
    exp_q.delete();
    mp = 3;
    held = '0;
    for (int c = 0; c < 16; c++) begin
      stall = (c >= 4 && c <= 6);
      out_ready = !stall;
      in_valid = 4'hF;
      for (int i = 0; i < 4; i++) in_data[i*16 +: 16] = 16'(16'h0100 + c*16 + i);
      #1;
      checks++;
      if (stall) begin
        if (in_ready !== 4'b0000)
          begin fails++; $display("FAIL bp_ready c=%0d: got %b want 0000", c, in_ready); end
        if (c == 4) held = {out_ch, out_data};
        else begin
          checks++;
          if (out_valid !== 1'b1 || {out_ch, out_data} !== held)
            begin fails++; $display("FAIL bp_hold c=%0d: got v=%0b ch=%0d d=%h want v=1 ch=%0d d=%h", c, out_valid, out_ch, out_data, held[17:16], held[15:0]); end
        end
      end else begin
        g = (mp + 1) % 4;
        if (in_ready !== (4'b0001 << g))
          begin fails++; $display("FAIL bp_grant c=%0d: got %b want %b", c, in_ready, 4'b0001 << g); end
        exp_q.push_back({2'(g), 16'(16'h0100 + c*16 + g)});
        mp = g;
        if (out_valid) begin
          checks++;
          e = (exp_q.size() > 1) ? exp_q.pop_front() : 18'h3FFFF;
          if ({out_ch, out_data} !== e)
            begin fails++; $display("FAIL bp_out c=%0d: got ch=%0d d=%h want ch=%0d d=%h", c, out_ch, out_data, e[17:16], e[15:0]); end
        end
      end
      tick();
    end
    in_valid = '0;
    out_ready = 1'b1;
    for (int d = 0; d < 5; d++) begin
      #1;
      if (out_valid) begin
        checks++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 18'h3FFFF;
        if ({out_ch, out_data} !== e)
          begin fails++; $display("FAIL bp_drain d=%0d: got ch=%0d d=%h want ch=%0d d=%h", d, out_ch, out_data, e[17:16], e[15:0]); end
      end
      tick();
    end
    checks++;
    if (exp_q.size() != 0)
      begin fails++; $display("FAIL bp_lost: got %0d outstanding want 0", exp_q.size()); end
  endtask

  task automatic test_cfg_same_cycle();
    do_reset();
    in_valid = 4'b0010;
    in_data[16 +: 16] = 16'h0010;
    cfg_wr = 1'b1; cfg_ch = 2'd1; cfg_shift = 5'd2; cfg_sat_en = 1'b1;
    tick();
    cfg_wr = 1'b0;
    tick();
    in_valid = '0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h0010 || out_ch !== 2'd1)
      begin fails++; $display("FAIL cfg_old: got v=%0b d=%h ch=%0d want 1 0010 1", out_valid, out_data, out_ch); end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h0040 || out_ch !== 2'd1)
      begin fails++; $display("FAIL cfg_new: got v=%0b d=%h ch=%0d want 1 0040 1", out_valid, out_data, out_ch); end
    tick();
  endtask

  task automatic test_reset_midflight();
    int n;
    cfg(0, 5'd4, 1'b1);
    send(0, 16'h0001);
    send(1, 16'h0002);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (out_valid !== 1'b0 || u_out_valid !== 1'b0)
        begin fails++; $display("FAIL reset_flush c=%0d: got v=%0b/%0b want 0/0", c, out_valid, u_out_valid); end
      tick();
    end
    in_valid = 4'hF;
    for (int i = 0; i < 4; i++) in_data[i*16 +: 16] = 16'h1234;
    #1;
    checks++;
    if (in_ready !== 4'b0001)
      begin fails++; $display("FAIL reset_grant: got %b want 0001", in_ready); end
    tick();
    in_valid = '0;
    wait_out(n);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h1234 || out_ch !== 2'd0 || out_sat !== 1'b0)
      begin fails++; $display("FAIL reset_cfg_default: got v=%0b d=%h ch=%0d sat=%0b want 1 1234 0 0", out_valid, out_data, out_ch, out_sat); end
    tick();
  endtask

  task automatic test_unsigned();
    int n;
    do_reset();
    cfg(0, 5'd1, 1'b1);
    send(0, 16'h9000);
    wait_out(n);
    checks++;
    if (u_out_valid !== 1'b1 || u_out_data !== 16'hFFFF || u_out_sat !== 1'b1)
      begin fails++; $display("FAIL uns_left: got v=%0b d=%h sat=%0b want 1 ffff 1", u_out_valid, u_out_data, u_out_sat); end
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h8000 || out_sat !== 1'b1)
      begin fails++; $display("FAIL sgn_left: got v=%0b d=%h sat=%0b want 1 8000 1", out_valid, out_data, out_sat); end
    cfg(0, 5'b11111, 1'b1);
    send(0, 16'h9000);
    wait_out(n);
    checks++;
    if (u_out_valid !== 1'b1 || u_out_data !== 16'h4800 || u_out_sat !== 1'b0)
      begin fails++; $display("FAIL uns_right: got v=%0b d=%h sat=%0b want 1 4800 0", u_out_valid, u_out_data, u_out_sat); end
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'hC800 || out_sat !== 1'b0)
      begin fails++; $display("FAIL sgn_right: got v=%0b d=%h sat=%0b want 1 c800 0", out_valid, out_data, out_sat); end
    tick();
  endtask

  // Sequence and final report
  initial begin
    test_reset();
    test_shift_left();
    test_shift_right();
    test_saturation();
    test_round_robin();
    test_backpressure();
    test_cfg_same_cycle();
    test_reset_midflight();
    test_unsigned();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
